// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for a 5-stage MIPS-style core.
// Captures decoded ID-stage fields, inserts bubbles on flush or load-use
// hazards, freezes on hold, and forwards EX operands from EX/MEM and MEM/WB.
module id_ex_stage #(
  parameter logic [31:0] NOP_IR = 32'h00000000,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // ID-stage datapath
  input  logic [31:0] id_IR,
  input  logic [31:0] id_RegA,
  input  logic [31:0] id_RegB,
  input  logic [31:0] id_PC_plus_4,
  input  logic [31:0] id_LU_out,
  // ID-stage control
  input  logic        id_ALUSrc1,
  input  logic        id_ALUSrc2,
  input  logic [3:0]  id_ALUOp,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_RegWrite,
  input  logic [1:0]  id_MemtoReg,
  input  logic        id_Branch,
  input  logic [4:0]  id_WriteReg,
  input  logic        id_uses_rt,
  // pipeline control
  input  logic        flush,
  input  logic        hold,
  // forwarding sources
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_WriteReg,
  input  logic [31:0] exmem_ALUout,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_WriteReg,
  input  logic [31:0] memwb_WriteData,
  // EX-stage outputs
  output logic [31:0] IR,
  output logic [31:0] PC_plus_4,
  output logic [31:0] LU_out,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [3:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        Branch,
  output logic [4:0]  WriteReg,
  output logic        valid,
  output logic [31:0] RegA,
  output logic [31:0] RegB,
  output logic        load_use_stall
);

  // Register-file values captured from ID, before forwarding.
  logic [31:0] rega_reg;
  logic [31:0] regb_reg;

  // Load-use hazard: the load sitting in EX writes a register the ID
  // instruction reads. Flush wins (the ID instruction is being discarded),
  // and nothing advances during hold or reset, so no stall is requested then.
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (WriteReg == id_IR[25:21]);
  assign rt_hit = id_uses_rt && (WriteReg == id_IR[20:16]);

  assign load_use_stall = valid && MemRead && (WriteReg != 5'd0) &&
                          (rs_hit || rt_hit) && !flush && !hold && !reset;

  // Pipeline register: reset and bubbles leave the same empty state
  // (NOP in IR, everything else zero); hold freezes; otherwise load from ID.
  always_ff @(posedge clk) begin
    if (reset || flush || (!hold && load_use_stall)) begin
      IR        <= NOP_IR;
      rega_reg  <= 32'd0;
      regb_reg  <= 32'd0;
      PC_plus_4 <= 32'd0;
      LU_out    <= 32'd0;
      ALUSrc1   <= 1'b0;
      ALUSrc2   <= 1'b0;
      ALUOp     <= 4'd0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      RegWrite  <= 1'b0;
      MemtoReg  <= 2'd0;
      Branch    <= 1'b0;
      WriteReg  <= 5'd0;
      valid     <= 1'b0;
    end else if (!hold) begin
      IR        <= id_IR;
      rega_reg  <= id_RegA;
      regb_reg  <= id_RegB;
      PC_plus_4 <= id_PC_plus_4;
      LU_out    <= id_LU_out;
      ALUSrc1   <= id_ALUSrc1;
      ALUSrc2   <= id_ALUSrc2;
      ALUOp     <= id_ALUOp;
      MemRead   <= id_MemRead;
      MemWrite  <= id_MemWrite;
      RegWrite  <= id_RegWrite;
      MemtoReg  <= id_MemtoReg;
      Branch    <= id_Branch;
      WriteReg  <= id_WriteReg;
      valid     <= 1'b1;
    end
  end

  // Operand 0 is rs (feeds RegA), operand 1 is rt (feeds RegB; also the
  // store data, so it is forwarded regardless of ALUSrc2).
  logic [1:0][4:0]  src;
  logic [1:0][31:0] reg_val;
  logic [1:0][31:0] fwd_val;

  assign src[0]     = IR[25:21];
  assign src[1]     = IR[20:16];
  assign reg_val[0] = rega_reg;
  assign reg_val[1] = regb_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic exmem_hit;
      logic memwb_hit;

      assign exmem_hit = exmem_RegWrite && (exmem_WriteReg != 5'd0) &&
                         (exmem_WriteReg == src[gi]);
      assign memwb_hit = memwb_RegWrite && (memwb_WriteReg != 5'd0) &&
                         (memwb_WriteReg == src[gi]);

      // Youngest producer wins: EX/MEM before MEM/WB before register file.
      always_comb begin
        fwd_val[gi] = reg_val[gi];
        if (FWD_EN) begin
          if (exmem_hit) begin
            fwd_val[gi] = exmem_ALUout;
          end else if (memwb_hit) begin
            fwd_val[gi] = memwb_WriteData;
          end
        end
      end
    end
  endgenerate

  assign RegA = fwd_val[0];
  assign RegB = fwd_val[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the stimulus process queues expected
// values tagged with the cycle they must appear in; a monitor on the falling
// edge pops and compares them.
module tb_id_ex_stage;

  localparam logic [31:0] TB_NOP = 32'h00000040;

  localparam int S_IR    = 0;
  localparam int S_REGA  = 1;
  localparam int S_REGB  = 2;
  localparam int S_VALID = 3;
  localparam int S_RW    = 4;
  localparam int S_MR    = 5;
  localparam int S_WR    = 6;
  localparam int S_LUS   = 7;
  localparam int S_PC    = 8;
  localparam int S_LU    = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_IR, id_RegA, id_RegB, id_PC_plus_4, id_LU_out;
  logic        id_ALUSrc1, id_ALUSrc2, id_MemRead, id_MemWrite, id_RegWrite, id_Branch;
  logic [3:0]  id_ALUOp;
  logic [1:0]  id_MemtoReg;
  logic [4:0]  id_WriteReg;
  logic        id_uses_rt, flush, hold;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_WriteReg, memwb_WriteReg;
  logic [31:0] exmem_ALUout, memwb_WriteData;
  logic [31:0] IR, PC_plus_4, LU_out, RegA, RegB;
  logic        ALUSrc1, ALUSrc2, MemRead, MemWrite, RegWrite, Branch, valid, load_use_stall;
  logic [3:0]  ALUOp;
  logic [1:0]  MemtoReg;
  logic [4:0]  WriteReg;

  id_ex_stage #(.NOP_IR(TB_NOP), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .id_IR(id_IR), .id_RegA(id_RegA), .id_RegB(id_RegB),
    .id_PC_plus_4(id_PC_plus_4), .id_LU_out(id_LU_out),
    .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2), .id_ALUOp(id_ALUOp),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite),
    .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_WriteReg(id_WriteReg),
    .id_uses_rt(id_uses_rt), .flush(flush), .hold(hold),
    .exmem_RegWrite(exmem_RegWrite), .exmem_WriteReg(exmem_WriteReg),
    .exmem_ALUout(exmem_ALUout), .memwb_RegWrite(memwb_RegWrite),
    .memwb_WriteReg(memwb_WriteReg), .memwb_WriteData(memwb_WriteData),
    .IR(IR), .PC_plus_4(PC_plus_4), .LU_out(LU_out),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .Branch(Branch), .WriteReg(WriteReg), .valid(valid),
    .RegA(RegA), .RegB(RegB), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // delay 0: combinational result this cycle; delay 1: after the next posedge
  task automatic expect_val(input int delay, input string name, input int sig,
                            input logic [31:0] val);
    exp_t e;
    e.at = cyc + delay; e.name = name; e.sig = sig; e.val = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_IR:    return IR;
      S_REGA:  return RegA;
      S_REGB:  return RegB;
      S_VALID: return {31'd0, valid};
      S_RW:    return {31'd0, RegWrite};
      S_MR:    return {31'd0, MemRead};
      S_WR:    return {27'd0, WriteReg};
      S_LUS:   return {31'd0, load_use_stall};
      S_PC:    return PC_plus_4;
      S_LU:    return LU_out;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  // Monitor: compare every queued expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      checks++;
      if (e.at != cyc) begin
        errors++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.at, cyc);
      end else begin
        a = actual(e.sig);
        if (a !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, a, e.val);
        end else begin
          $display("ok   %s: %h (cycle %0d)", e.name, a, cyc);
        end
      end
    end
  end

  task automatic clear_id();
    id_IR = 32'd0; id_RegA = 32'd0; id_RegB = 32'd0; id_PC_plus_4 = 32'd0; id_LU_out = 32'd0;
    id_ALUSrc1 = 0; id_ALUSrc2 = 0; id_ALUOp = 4'd0; id_MemRead = 0; id_MemWrite = 0;
    id_RegWrite = 0; id_MemtoReg = 2'd0; id_Branch = 0; id_WriteReg = 5'd0; id_uses_rt = 0;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] ewr, input logic [31:0] eval,
                         input logic mrw, input logic [4:0] mwr, input logic [31:0] mval);
    exmem_RegWrite = erw; exmem_WriteReg = ewr; exmem_ALUout = eval;
    memwb_RegWrite = mrw; memwb_WriteReg = mwr; memwb_WriteData = mval;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    clear_id();
    set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then load add $8,$9,$10
    expect_val(0, "reset_IR", S_IR, TB_NOP);
    expect_val(0, "reset_valid", S_VALID, 32'd0);
    expect_val(0, "reset_RegWrite", S_RW, 32'd0);
    expect_val(0, "reset_PC", S_PC, 32'd0);
    expect_val(0, "reset_stall", S_LUS, 32'd0);
    reset = 1'b0;
    id_IR = 32'h012A4020; id_RegA = 32'd5; id_RegB = 32'd7; id_RegWrite = 1;
    id_WriteReg = 5'd8; id_PC_plus_4 = 32'h104; id_uses_rt = 1;
    expect_val(1, "add_IR", S_IR, 32'h012A4020);
    expect_val(1, "add_RegA", S_REGA, 32'd5);
    expect_val(1, "add_RegB", S_REGB, 32'd7);
    expect_val(1, "add_valid", S_VALID, 32'd1);
    expect_val(1, "add_PC", S_PC, 32'h104);
    expect_val(1, "add_WriteReg", S_WR, 32'd8);

    // lw $8,0($9)
    step();
    id_IR = 32'h8D280000; id_RegA = 32'h100; id_MemRead = 1; id_RegWrite = 1;
    id_WriteReg = 5'd8; id_uses_rt = 0; id_LU_out = 32'd0;
    expect_val(0, "add_no_stall", S_LUS, 32'd0);
    expect_val(1, "lw_MemRead", S_MR, 32'd1);
    expect_val(1, "lw_IR", S_IR, 32'h8D280000);

    // add $10,$8,$11 right behind the load: one bubble
    step();
    clear_id();
    id_IR = 32'h010B5020; id_RegA = 32'h11; id_RegB = 32'h22; id_RegWrite = 1;
    id_WriteReg = 5'd10; id_uses_rt = 1;
    expect_val(0, "loaduse_stall", S_LUS, 32'd1);
    expect_val(1, "bubble_IR", S_IR, TB_NOP);
    expect_val(1, "bubble_valid", S_VALID, 32'd0);
    expect_val(1, "bubble_RegWrite", S_RW, 32'd0);
    expect_val(1, "bubble_MemRead", S_MR, 32'd0);
    expect_val(1, "bubble_WriteReg", S_WR, 32'd0);

    // same ID instruction re-presented; stall must clear
    step();
    expect_val(0, "stall_released", S_LUS, 32'd0);
    expect_val(1, "dep_IR", S_IR, 32'h010B5020);
    expect_val(1, "dep_valid", S_VALID, 32'd1);
    expect_val(1, "dep_RegA", S_REGA, 32'h11);

    // add $12,$9,$13 with ALUSrc2 set
    step();
    clear_id();
    id_IR = 32'h012D6020; id_RegA = 32'h99; id_RegB = 32'h77; id_RegWrite = 1;
    id_WriteReg = 5'd12; id_uses_rt = 1; id_ALUSrc2 = 1;
    expect_val(1, "fw_IR", S_IR, 32'h012D6020);

    // hold for several cycles while exercising forwarding
    step();
    hold = 1;
    set_fwd(1, 5'd9, 32'h0000AAAA, 1, 5'd9, 32'h0000BBBB);
    expect_val(0, "fw_exmem_prio", S_REGA, 32'h0000AAAA);
    expect_val(0, "fw_rt_nomatch", S_REGB, 32'h77);

    step();
    id_IR = 32'hFFFFFFFF; id_RegA = 32'h123; id_MemRead = 1; id_WriteReg = 5'd31;
    set_fwd(0, 5'd9, 32'h0000AAAA, 1, 5'd9, 32'h0000BBBB);
    expect_val(0, "fw_memwb", S_REGA, 32'h0000BBBB);
    expect_val(0, "hold_IR_1", S_IR, 32'h012D6020);

    step();
    id_IR = 32'h8C1F0000; id_PC_plus_4 = 32'h999;
    set_fwd(1, 5'd13, 32'h0000AAAA, 1, 5'd9, 32'h0000BBBB);
    expect_val(0, "fw_rt_store", S_REGB, 32'h0000AAAA);
    expect_val(0, "fw_rs_memwb", S_REGA, 32'h0000BBBB);
    expect_val(0, "hold_IR_2", S_IR, 32'h012D6020);

    step();
    set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    expect_val(0, "nofw_RegA", S_REGA, 32'h99);
    expect_val(0, "nofw_RegB", S_REGB, 32'h77);
    expect_val(0, "hold_valid", S_VALID, 32'd1);
    expect_val(0, "hold_PC", S_PC, 32'd0);

    // flush together with hold: bubble wins
    step();
    flush = 1;
    expect_val(1, "flushhold_IR", S_IR, TB_NOP);
    expect_val(1, "flushhold_valid", S_VALID, 32'd0);
    expect_val(1, "flushhold_RegWrite", S_RW, 32'd0);

    // add $3,$0,$0: register 0 is never forwarded
    step();
    hold = 0; flush = 0;
    clear_id();
    id_IR = 32'h00001820; id_RegWrite = 1; id_WriteReg = 5'd3; id_uses_rt = 1;
    expect_val(1, "r0_IR", S_IR, 32'h00001820);

    step();
    set_fwd(1, 5'd0, 32'h0000DEAD, 1, 5'd0, 32'h0000BEEF);
    expect_val(0, "r0_RegA", S_REGA, 32'd0);
    expect_val(0, "r0_RegB", S_REGB, 32'd0);
    clear_id();
    id_IR = 32'h8C050000; id_MemRead = 1; id_RegWrite = 1; id_WriteReg = 5'd5;
    id_LU_out = 32'h55; id_PC_plus_4 = 32'h200;
    expect_val(1, "lw5_MemRead", S_MR, 32'd1);
    expect_val(1, "lw5_LU", S_LU, 32'h55);

    // add $6,$5,$0 behind the load, with flush and reset in the same cycle
    step();
    set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    clear_id();
    id_IR = 32'h00A03020; id_RegWrite = 1; id_WriteReg = 5'd6; id_uses_rt = 1;
    id_PC_plus_4 = 32'h204;
    flush = 1; reset = 1;
    expect_val(0, "flush_overrides_stall", S_LUS, 32'd0);
    expect_val(1, "rst2_IR", S_IR, TB_NOP);
    expect_val(1, "rst2_valid", S_VALID, 32'd0);
    expect_val(1, "rst2_MemRead", S_MR, 32'd0);
    expect_val(1, "rst2_PC", S_PC, 32'd0);
    expect_val(1, "rst2_LU", S_LU, 32'd0);

    step();
    flush = 0; reset = 0;
    expect_val(0, "post_reset_stall", S_LUS, 32'd0);
    expect_val(1, "post_reset_IR", S_IR, 32'h00A03020);
    expect_val(1, "post_reset_valid", S_VALID, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
